// File: rtl/counter_stream_checker.sv
// rtl/counter_stream_checker.sv - counter stream receive-side sequence checker
module counter_stream_checker #(
    parameter int W          = 8,
    parameter int CW         = 16,
    parameter int RESYNC_CYC = 2
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          lock,
    output logic          err_pulse,
    output logic [W-1:0]  expected,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] beat_count
);

    // Back-off counter must hold RESYNC_CYC-1; it counts down to zero.
    localparam int RW = (RESYNC_CYC > 1) ? $clog2(RESYNC_CYC) : 1;

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED,
        RESYNC
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [RW-1:0]   rs_cnt;
    logic [RW-1:0]   rs_cnt_nx;
    logic [W-1:0]    expected_nx;
    logic [CW-1:0]   err_count_nx;
    logic [CW-1:0]   beat_count_nx;
    logic            err_pulse_nx;
    logic            accept;

    // A beat is taken only when the registered ready meets a valid.
    assign accept = in_valid & in_ready;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == '1) ? c : c + CW'(1);
    endfunction

    // Next-state, next-expected and counter updates; clear overrides any beat.
    always_comb begin
        state_nx      = state;
        rs_cnt_nx     = rs_cnt;
        expected_nx   = expected;
        err_count_nx  = err_count;
        beat_count_nx = beat_count;
        err_pulse_nx  = 1'b0;
        if (clear) begin
            state_nx      = UNLOCKED;
            rs_cnt_nx     = '0;
            expected_nx   = '0;
            err_count_nx  = '0;
            beat_count_nx = '0;
        end else begin
            case (state)
                UNLOCKED: begin
                    if (accept) begin
                        expected_nx   = in_data + W'(1);
                        beat_count_nx = sat_inc(beat_count);
                        state_nx      = LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        if (in_data == expected) begin
                            expected_nx   = expected + W'(1);
                            beat_count_nx = sat_inc(beat_count);
                        end else begin
                            err_pulse_nx = 1'b1;
                            err_count_nx = sat_inc(err_count);
                            rs_cnt_nx    = RW'(RESYNC_CYC - 1);
                            state_nx     = RESYNC;
                        end
                    end
                end
                RESYNC: begin
                    if (rs_cnt == '0) begin
                        state_nx = UNLOCKED;
                    end else begin
                        rs_cnt_nx = rs_cnt - RW'(1);
                    end
                end
                default: state_nx = UNLOCKED;
            endcase
        end
    end

    // State and registered outputs; ready/lock are derived from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= UNLOCKED;
            rs_cnt     <= '0;
            in_ready   <= 1'b1;
            lock       <= 1'b0;
            err_pulse  <= 1'b0;
            expected   <= '0;
            err_count  <= '0;
            beat_count <= '0;
        end else begin
            state      <= state_nx;
            rs_cnt     <= rs_cnt_nx;
            in_ready   <= (state_nx != RESYNC);
            lock       <= (state_nx == LOCKED);
            err_pulse  <= err_pulse_nx;
            expected   <= expected_nx;
            err_count  <= err_count_nx;
            beat_count <= beat_count_nx;
        end
    end

endmodule

// File: tb/tb_counter_stream_checker.sv
// tb/tb_counter_stream_checker.sv - scoreboard bench for counter_stream_checker
module tb_counter_stream_checker;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        lock;
    logic        err_pulse;
    logic [7:0]  expected;
    logic [15:0] err_count;
    logic [15:0] beat_count;

    logic        clear2;
    logic        v2;
    logic [7:0]  d2;
    logic        ready2;
    logic        lock2;
    logic        pulse2;
    logic [7:0]  exp2;
    logic [3:0]  ec2;
    logic [3:0]  bc2;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0]  d;
        logic        lk;
        logic        pl;
        logic [7:0]  ex;
        logic [15:0] ec;
        logic [15:0] bc;
    } exp_t;

    exp_t sbq[$];

    counter_stream_checker #(.W(8), .CW(16), .RESYNC_CYC(2)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .lock(lock),
        .err_pulse(err_pulse), .expected(expected),
        .err_count(err_count), .beat_count(beat_count)
    );

    counter_stream_checker #(.W(8), .CW(4), .RESYNC_CYC(2)) dut_sat (
        .clk(clk), .n_rst(n_rst), .clear(clear2), .in_valid(v2),
        .in_data(d2), .in_ready(ready2), .lock(lock2),
        .err_pulse(pulse2), .expected(exp2),
        .err_count(ec2), .beat_count(bc2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", in_ready, 1);
    endtask

    task automatic send(input logic [7:0] d, input logic lk, input logic pl,
                        input logic [7:0] ex, input logic [15:0] ec, input logic [15:0] bc);
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        sbq.push_back('{d, lk, pl, ex, ec, bc});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] d);
        int n = 0;
        while (!ready2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready2_timeout", ready2, 1);
        v2 = 1'b1;
        d2 = d;
        @(negedge clk);
        v2 = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_lock"}, lock, 0);
        chk({tag, "_err_pulse"}, err_pulse, 0);
        chk({tag, "_expected"}, expected, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_beat_count"}, beat_count, 0);
    endtask

    // Monitor: every accepted beat yields one registered status update next cycle.
    initial begin
        logic hs;
        exp_t e;
        forever begin
            @(posedge clk);
            hs = n_rst && !clear && in_valid && in_ready;
            @(negedge clk);
            if (hs) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("lock_d%0d", e.d), lock, e.lk);
                    chk($sformatf("err_pulse_d%0d", e.d), err_pulse, e.pl);
                    chk($sformatf("expected_d%0d", e.d), expected, e.ex);
                    chk($sformatf("err_count_d%0d", e.d), err_count, e.ec);
                    chk($sformatf("beat_count_d%0d", e.d), beat_count, e.bc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_rst    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        clear2   = 1'b0;
        v2       = 1'b0;
        d2       = '0;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst");

        // 1: lock on 5, then 6,7,8
        send(8'd5, 1, 0, 8'd6, 0, 1);
        send(8'd6, 1, 0, 8'd7, 0, 2);
        send(8'd7, 1, 0, 8'd8, 0, 3);
        send(8'd8, 1, 0, 8'd9, 0, 4);

        // 2: wrap 255 -> 0
        pulse_clear();
        chk("clr1_beat_count", beat_count, 0);
        send(8'd254, 1, 0, 8'd255, 0, 1);
        send(8'd255, 1, 0, 8'd0,   0, 2);
        send(8'd0,   1, 0, 8'd1,   0, 3);
        send(8'd1,   1, 0, 8'd2,   0, 4);

        // 3: mismatch at expected=10, back-off, relock on 40
        pulse_clear();
        send(8'd8,  1, 0, 8'd9,  0, 1);
        send(8'd9,  1, 0, 8'd10, 0, 2);
        send(8'd12, 0, 1, 8'd10, 1, 2);
        chk("rs_ready_c1", in_ready, 0);
        @(negedge clk);
        chk("rs_ready_c2", in_ready, 0);
        chk("rs_pulse_c2", err_pulse, 0);
        @(negedge clk);
        chk("rs_ready_c3", in_ready, 1);
        chk("rs_lock_c3", lock, 0);
        send(8'd40, 1, 0, 8'd41, 1, 3);

        // 4: idle gaps are not errors; valid held through back-off
        send(8'd41, 1, 0, 8'd42, 1, 4);
        send(8'd42, 1, 0, 8'd43, 1, 5);
        repeat (3) @(negedge clk);
        chk("gap_lock", lock, 1);
        chk("gap_err_count", err_count, 1);
        send(8'd43, 1, 0, 8'd44, 1, 6);
        send(8'd50, 0, 1, 8'd44, 2, 6);
        in_valid = 1'b1;
        in_data  = 8'd60;
        @(negedge clk);
        chk("hold_ready", in_ready, 0);
        chk("hold_beat_count", beat_count, 6);
        chk("hold_err_count", err_count, 2);
        send(8'd60, 1, 0, 8'd61, 2, 7);

        // 5: clear beats a same-cycle wrong beat; clear aborts back-off
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        chk_reset_vals("clr_beat");
        send(8'd1, 1, 0, 8'd2, 0, 1);
        send(8'd5, 0, 1, 8'd2, 1, 1);
        chk("rs_abort_ready_pre", in_ready, 0);
        pulse_clear();
        chk_reset_vals("rs_abort");
        send(8'd77, 1, 0, 8'd78, 0, 1);

        // 6a: saturation on the CW=4 instance
        for (int i = 1; i <= 17; i++) begin
            send2(8'd0);
            chk($sformatf("sat_bc_%0d", i), bc2, (i > 15) ? 15 : i);
            send2(8'd100);
            chk($sformatf("sat_ec_%0d", i), ec2, (i > 15) ? 15 : i);
            chk($sformatf("sat_pulse_%0d", i), pulse2, 1);
        end

        // 6b: asynchronous reset mid-stream, then relock without error
        send(8'd78, 1, 0, 8'd79, 0, 2);
        #2;
        n_rst = 1'b0;
        #1;
        chk_reset_vals("arst");
        chk("arst_sat_ec", ec2, 0);
        chk("arst_sat_bc", bc2, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        send(8'd200, 1, 0, 8'd201, 0, 1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
